// File: rtl/i2c_bus_sampler_if.sv
// Bus-facing signal bundle for the I2C input sampler.
// Handshake semantics: every strobe (scl_rise, scl_fall, start, stop,
// byte_valid, ack_valid) is a one-clock valid pulse with no ready; the
// consumer must take it in the cycle it is high. rx_byte and ack are
// qualified by byte_valid and ack_valid respectively and hold between pulses.
// bit_cnt is an observation-only view of the bit assembly counter.
interface i2c_bus_sampler_if;
    logic       scl_i;
    logic       sda_i;
    logic       filter_en;
    logic       scl;
    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;
    logic       bus_busy;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       ack_valid;
    logic       ack;
    logic [3:0] bit_cnt;

    modport slave (
        input  scl_i, sda_i, filter_en,
        output scl, sda, scl_rise, scl_fall, start, stop, bus_busy,
               byte_valid, rx_byte, ack_valid, ack, bit_cnt
    );

    modport master (
        output scl_i, sda_i, filter_en,
        input  scl, sda, scl_rise, scl_fall, start, stop, bus_busy,
               byte_valid, rx_byte, ack_valid, ack, bit_cnt
    );
endinterface

// File: rtl/i2c_bus_sampler.sv
// I2C input front end: synchronises and glitch-filters SCL/SDA, detects SCL
// edges and START/STOP, and assembles received bits into bytes plus ACK.
// Line index 0 is SCL, index 1 is SDA throughout.
module i2c_bus_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input logic               clk,
    input logic               rst_n,
    i2c_bus_sampler_if.slave  bus
);

    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [3:0]             cnt_q  [2];
    logic [1:0]             filt_q;
    logic [1:0]             line_raw;
    logic [1:0]             line_s;
    logic [1:0]             line_f;

    logic       scl_d, sda_d;
    logic       rise_c, fall_c, start_c, stop_c;
    logic       scl_rise_q, scl_fall_q, start_q, stop_q;
    logic       busy_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] rx_byte_q;
    logic       byte_valid_q, ack_valid_q, ack_q;

    // Select synchroniser tail and filtered/bypassed levels per line.
    always_comb begin
        line_raw = {bus.sda_i, bus.scl_i};
        for (int i = 0; i < 2; i++) begin
            line_s[i] = sync_q[i][SYNC_STAGES-1];
        end
        line_f = bus.filter_en ? filt_q : line_s;
    end

    // Synchroniser chains; reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) sync_q[i] <= '1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], line_raw[i]};
            end
        end
    end

    // Glitch filter: a line only changes after FILTER_LEN consecutive differing clocks.
    // In bypass the filtered register tracks the synchroniser so re-enabling is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!bus.filter_en) begin
                    filt_q[i] <= line_s[i];
                    cnt_q[i]  <= '0;
                end else if (line_s[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == 4'(FILTER_LEN - 1)) begin
                    filt_q[i] <= line_s[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Edge and bus-condition decode; SDA moving with SCL is neither START nor STOP.
    always_comb begin
        rise_c  =  line_f[0] & ~scl_d;
        fall_c  = ~line_f[0] &  scl_d;
        start_c =  line_f[0] &  scl_d & ~line_f[1] &  sda_d;
        stop_c  =  line_f[0] &  scl_d &  line_f[1] & ~sda_d;
    end

    // Registered strobes, busy flag and bit assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d        <= 1'b1;
            sda_d        <= 1'b1;
            scl_rise_q   <= 1'b0;
            scl_fall_q   <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            busy_q       <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            ack_valid_q  <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            scl_d        <= line_f[0];
            sda_d        <= line_f[1];
            scl_rise_q   <= rise_c;
            scl_fall_q   <= fall_c;
            start_q      <= start_c;
            stop_q       <= stop_c;
            byte_valid_q <= 1'b0;
            ack_valid_q  <= 1'b0;

            if (start_c) begin
                busy_q <= 1'b1;
            end else if (stop_c) begin
                busy_q <= 1'b0;
            end

            // START/STOP cannot coincide with an SCL rise, so these branches are exclusive.
            if (start_c || stop_c) begin
                bit_cnt_q <= '0;
            end else if (rise_c && busy_q) begin
                if (bit_cnt_q < 4'd8) begin
                    shift_q   <= {shift_q[6:0], line_f[1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        byte_valid_q <= 1'b1;
                        rx_byte_q    <= {shift_q[6:0], line_f[1]};
                    end
                end else begin
                    ack_valid_q <= 1'b1;
                    ack_q       <= line_f[1];
                    bit_cnt_q   <= '0;
                end
            end
        end
    end

    assign bus.scl        = line_f[0];
    assign bus.sda        = line_f[1];
    assign bus.scl_rise   = scl_rise_q;
    assign bus.scl_fall   = scl_fall_q;
    assign bus.start      = start_q;
    assign bus.stop       = stop_q;
    assign bus.bus_busy   = busy_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.rx_byte    = rx_byte_q;
    assign bus.ack_valid  = ack_valid_q;
    assign bus.ack        = ack_q;
    assign bus.bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_i2c_bus_sampler.sv
// Directed bench for i2c_bus_sampler at default parameters.
module tb_i2c_bus_sampler;

    logic clk;
    logic rst_n;

    i2c_bus_sampler_if bus ();

    i2c_bus_sampler #(
        .SYNC_STAGES (2),
        .FILTER_LEN  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // strobe monitor, sampled on the falling edge
    int         n_start = 0, n_stop = 0, n_rise = 0, n_fall = 0, n_byte = 0, n_ack = 0;
    logic [7:0] last_byte = 8'h00;
    logic       last_ack  = 1'b1;

    always @(negedge clk) begin
        if (bus.start)      n_start++;
        if (bus.stop)       n_stop++;
        if (bus.scl_rise)   n_rise++;
        if (bus.scl_fall)   n_fall++;
        if (bus.byte_valid) begin n_byte++; last_byte = bus.rx_byte; end
        if (bus.ack_valid)  begin n_ack++;  last_ack  = bus.ack;     end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        bus.scl_i = 1'b0; tick(8);
        bus.sda_i = b;    tick(8);
        bus.scl_i = 1'b1; tick(8);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_start();
        bus.scl_i = 1'b0; tick(8);
        bus.sda_i = 1'b1; tick(8);
        bus.scl_i = 1'b1; tick(8);
        bus.sda_i = 1'b0; tick(8);
    endtask

    task automatic do_stop();
        bus.scl_i = 1'b0; tick(8);
        bus.sda_i = 1'b0; tick(8);
        bus.scl_i = 1'b1; tick(8);
        bus.sda_i = 1'b1; tick(8);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_scl"},   32'(bus.scl), 32'd1);
        check_val({tag, "_sda"},   32'(bus.sda), 32'd1);
        check_val({tag, "_strb"},  32'({bus.scl_rise, bus.scl_fall, bus.start, bus.stop,
                                        bus.byte_valid, bus.ack_valid}), 32'd0);
        check_val({tag, "_busy"},  32'(bus.bus_busy), 32'd0);
        check_val({tag, "_rxb"},   32'(bus.rx_byte), 32'd0);
        check_val({tag, "_ack"},   32'(bus.ack), 32'd0);
        check_val({tag, "_bcnt"},  32'(bus.bit_cnt), 32'd0);
    endtask

    int s0, s1, s2, s3, s4, s5;

    initial begin
        rst_n         = 1'b1;
        bus.scl_i     = 1'b1;
        bus.sda_i     = 1'b1;
        bus.filter_en = 1'b1;
        #1 rst_n = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 4; i++) begin
            bus.scl_i = 1'($urandom_range(0, 1));
            bus.sda_i = 1'($urandom_range(0, 1));
            tick(1);
        end
        check_reset_outputs("reset");
        bus.scl_i = 1'b1;
        bus.sda_i = 1'b1;
        tick(2);
        rst_n = 1'b1;
        s0 = n_start + n_stop + n_rise + n_fall + n_byte + n_ack;
        tick(20);
        check_val("idle_no_strobes", 32'(n_start + n_stop + n_rise + n_fall + n_byte + n_ack), 32'(s0));

        // START latency: SDA drops after edge 0, start exactly at edge 6
        bus.sda_i = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            check_val($sformatf("start_lat_e%0d", e), 32'(bus.start), (e == 6) ? 32'd1 : 32'd0);
            if (e == 6) check_val("busy_at_start", 32'(bus.bus_busy), 32'd1);
        end
        s0 = n_stop;
        bus.sda_i = 1'b1; tick(10);
        check_val("stop_after_lat", 32'(n_stop - s0), 32'd1);
        check_val("busy_after_stop", 32'(bus.bus_busy), 32'd0);

        // glitch filter: 2-clock low pulse is rejected
        s0 = n_start;
        bus.sda_i = 1'b0; tick(2);
        bus.sda_i = 1'b1; tick(12);
        check_val("glitch2_no_start", 32'(n_start - s0), 32'd0);
        check_val("glitch2_idle", 32'(bus.bus_busy), 32'd0);

        // 3-clock low pulse passes
        s0 = n_start;
        bus.sda_i = 1'b0; tick(3);
        bus.sda_i = 1'b1; tick(12);
        check_val("glitch3_start", 32'(n_start - s0), 32'd1);

        // bypass: 1-clock pulse passes
        bus.filter_en = 1'b0;
        tick(4);
        s0 = n_start;
        bus.sda_i = 1'b0; tick(1);
        bus.sda_i = 1'b1; tick(8);
        check_val("bypass_start", 32'(n_start - s0), 32'd1);
        bus.filter_en = 1'b1;
        tick(8);

        // byte 0xA5 then ACK=0, then STOP
        do_start();
        check_val("byte_busy", 32'(bus.bus_busy), 32'd1);
        s0 = n_byte; s1 = n_ack; s2 = n_rise; s3 = n_fall;
        send_bit(1'b1);
        check_val("one_bit_rise", 32'(n_rise - s2), 32'd1);
        check_val("one_bit_fall", 32'(n_fall - s3), 32'd1);
        check_val("one_bit_cnt", 32'(bus.bit_cnt), 32'd1);
        for (int i = 6; i >= 0; i--) begin
            logic [7:0] v;
            v = 8'hA5;
            send_bit(v[i]);
        end
        check_val("a5_byte_cnt", 32'(n_byte - s0), 32'd1);
        check_val("a5_rx_byte", 32'(last_byte), 32'hA5);
        check_val("a5_no_ack_yet", 32'(n_ack - s1), 32'd0);
        send_bit(1'b0);
        check_val("a5_ack_cnt", 32'(n_ack - s1), 32'd1);
        check_val("a5_ack", 32'(last_ack), 32'd0);
        check_val("a5_bitcnt_wrap", 32'(bus.bit_cnt), 32'd0);
        s0 = n_stop; s1 = n_byte;
        do_stop();
        check_val("a5_stop", 32'(n_stop - s0), 32'd1);
        check_val("a5_busy_clr", 32'(bus.bus_busy), 32'd0);
        check_val("a5_stop_no_byte", 32'(n_byte - s1), 32'd0);

        // repeated START mid-byte, then 0x3C with NACK
        do_start();
        s0 = n_start; s1 = n_byte; s2 = n_ack;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        do_start();
        check_val("rs_start", 32'(n_start - s0), 32'd1);
        check_val("rs_busy", 32'(bus.bus_busy), 32'd1);
        check_val("rs_no_byte", 32'(n_byte - s1), 32'd0);
        check_val("rs_bitcnt", 32'(bus.bit_cnt), 32'd0);
        check_val("rs_rx_hold", 32'(bus.rx_byte), 32'hA5);
        send_byte(8'h3C);
        send_bit(1'b1);
        check_val("3c_byte_cnt", 32'(n_byte - s1), 32'd1);
        check_val("3c_rx_byte", 32'(last_byte), 32'h3C);
        check_val("3c_ack_cnt", 32'(n_ack - s2), 32'd1);
        check_val("3c_nack", 32'(last_ack), 32'd1);
        do_stop();

        // STOP after 5 bits
        do_start();
        s0 = n_byte;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        check_val("abort5_bitcnt_pre", 32'(bus.bit_cnt), 32'd5);
        do_stop();
        check_val("abort5_no_byte", 32'(n_byte - s0), 32'd0);
        check_val("abort5_bitcnt", 32'(bus.bit_cnt), 32'd0);
        check_val("abort5_busy", 32'(bus.bus_busy), 32'd0);
        check_val("abort5_rx_hold", 32'(bus.rx_byte), 32'h3C);

        // async reset after 3 bits
        do_start();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_rst");
        bus.scl_i = 1'($urandom_range(0, 1));
        bus.sda_i = 1'($urandom_range(0, 1));
        tick(3);
        bus.scl_i = 1'b1;
        bus.sda_i = 1'b1;
        tick(3);
        rst_n = 1'b1;
        s0 = n_start + n_stop + n_rise + n_fall + n_byte + n_ack;
        tick(20);
        check_val("post_rst_quiet", 32'(n_start + n_stop + n_rise + n_fall + n_byte + n_ack), 32'(s0));

        // SCL toggling without START produces nothing
        s0 = n_byte; s1 = n_ack;
        for (int i = 0; i < 10; i++) begin
            bus.scl_i = 1'b0; tick(8);
            bus.scl_i = 1'b1; tick(8);
        end
        check_val("nostart_byte", 32'(n_byte - s0), 32'd0);
        check_val("nostart_ack", 32'(n_ack - s1), 32'd0);
        check_val("nostart_busy", 32'(bus.bus_busy), 32'd0);
        check_val("nostart_bitcnt", 32'(bus.bit_cnt), 32'd0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_bus_sampler.md
# i2c_bus_sampler

Input-side front end for the I2C target datapath. It samples raw SCL/SDA pad inputs, synchronises and glitch-filters them, and detects SCL edges and START/STOP conditions. It assembles received bits into bytes plus the 9th-bit ACK. Its filtered levels and strobes feed the negedge-clocked SDA output register and the protocol FSM downstream.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth per line; legal range 2..4.
- FILTER_LEN, 3: consecutive differing clocks needed before a filtered line changes; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- scl_i  in  1  raw SCL pad input.
- sda_i  in  1  raw SDA pad input.
- filter_en  in  1  1 = glitch filter active; 0 = bypass.
- scl  out  1  filtered SCL level.
- sda  out  1  filtered SDA level.
- scl_rise  out  1  one-clock strobe on a filtered SCL 0→1 transition.
- scl_fall  out  1  one-clock strobe on a filtered SCL 1→0 transition.
- start  out  1  one-clock strobe on a START or repeated START.
- stop  out  1  one-clock strobe on a STOP.
- bus_busy  out  1  high between START and STOP.
- byte_valid  out  1  one-clock strobe; rx_byte is valid this cycle.
- rx_byte  out  8  assembled byte, MSB first.
- ack_valid  out  1  one-clock strobe on the 9th SCL rise.
- ack  out  1  SDA level sampled on the 9th rise (0 = ACK).

## Operation
- **Reset values.** While rst_n=0, all synchroniser flops, filtered lines and previous-value registers are 1 (idle bus). All strobes, bus_busy, bit_cnt, rx_byte and ack are 0.
- **Synchroniser.** Each line passes through a SYNC_STAGES flop chain.
- **Glitch filter.** There is one counter per line.
  - If the synchronised value equals the filtered value, the counter is cleared.
  - Otherwise, when the counter equals FILTER_LEN-1, the filtered value takes the new level and the counter clears. If not, the counter increments.
  - With filter_en=0, the filtered value equals the synchroniser output combinationally and the counters are held at 0. filter_en changes take effect from the next edge.
- **Edge/condition detect.** This stage uses registered previous copies scl_d and sda_d. All strobes are registered.
  - scl_rise = scl & ~scl_d.
  - scl_fall = ~scl & scl_d.
  - start = scl & scl_d & ~sda & sda_d.
  - stop = scl & scl_d & sda & ~sda_d.
  - An SDA change in the same cycle as an SCL change is not START or STOP.
- **bus_busy.** Set on the edge that asserts start. Cleared on the edge that asserts stop.
- **Bit assembly.** bit_cnt runs 0..8 and is cleared by start or stop. On each scl_rise condition while busy:
  - bit_cnt<8: shift sda into the shift register LSB and increment bit_cnt.
  - bit_cnt reaching 8: assert byte_valid with rx_byte = the full shift value on the same edge.
  - bit_cnt==8: assert ack_valid with ack = sda, and set bit_cnt to 0.
  - SCL rises while not busy are ignored.
- **Aborts.** A repeated START or a STOP mid-byte discards partial bits; no byte_valid is issued. rx_byte holds its last valid value.

## Timing
- Raw change (stable) to strobe asserted: SYNC_STAGES+FILTER_LEN+1 rising edges. This is 6 edges at the defaults, or SYNC_STAGES+1 with bypass.
- Raw change to the scl/sda outputs: SYNC_STAGES+FILTER_LEN edges.
- Pulses shorter than FILTER_LEN clocks (after synchronisation) never reach the filtered outputs.
- byte_valid and ack_valid coincide with the scl_rise strobe of the 8th and 9th bits respectively.
- An asynchronous reset mid-byte returns every output to its reset value immediately. After release, the first event needs a fresh START.

## Test plan
- **Reset:** assert rst_n=0 with random inputs → scl=sda=1 and every other output 0. After release with both lines high, there are no strobes for 20 clocks.
- **START latency (defaults):** SCL high, drop SDA at edge 0 → start is high exactly at edge 6 for one clock; bus_busy goes 1 at edge 6.
- **Glitch filter:** SCL high, SDA low for 2 clocks → no start. SDA low for 3 clocks → start. With filter_en=0, a 1-clock low pulse → start.
- **Byte and ACK:** START, then send 0xA5 MSB-first, then ACK=0 → byte_valid once with rx_byte=0xA5, then ack_valid with ack=0. STOP → stop strobe and bus_busy=0.
- **Repeated START mid-byte:** START, 4 bits, repeated START → start strobe, bus_busy stays 1, no byte_valid. Next byte 0x3C → byte_valid with rx_byte=0x3C.
- **Abort cases:** STOP after 5 bits → no byte_valid and bit_cnt cleared. rst_n pulsed low after 3 bits → all outputs reset. SCL toggled afterwards without START → no byte_valid or ack_valid.
